// File: rtl/generador_rebotes_pkg.sv
// Shared state encoding and LFSR constants for the contact-bounce emulator.
package generador_rebotes_pkg;

    typedef enum logic [1:0] {
        StReposo,
        StRebote,
        StEspera
    } estado_t;

    localparam int unsigned LfsrAncho = 8;

    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (bit 7 is x^8)
    localparam logic [LfsrAncho-1:0] LfsrTaps = 8'hB8;

    // An all-zero LFSR would lock up, so a zero seed falls back to this
    localparam logic [LfsrAncho-1:0] SemillaCero = 8'h01;

endpackage

// File: rtl/lfsr_rebotes.sv
// Free-running 8-bit Fibonacci LFSR that supplies the bounce interval jitter.
module lfsr_rebotes
    import generador_rebotes_pkg::*;
#(
    parameter logic [LfsrAncho-1:0] SEMILLA = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [LfsrAncho-1:0] valor
);

    localparam logic [LfsrAncho-1:0] SemillaEf = (SEMILLA == '0) ? SemillaCero : SEMILLA;

    logic [LfsrAncho-1:0] valor_q;
    logic [LfsrAncho-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (en) begin
            valor_d = {valor_q[LfsrAncho-2:0], ^(valor_q & LfsrTaps)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor_q <= SemillaEf;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/generador_rebotes.sv
// Bounce emulator: each level change of senal_limpia becomes an odd burst of
// pseudo-randomly spaced toggles, followed by a guard period before re-arming.
module generador_rebotes
    import generador_rebotes_pkg::*;
#(
    parameter int unsigned N_REBOTES       = 3,
    parameter int unsigned ANCHO_INTERVALO = 4,
    parameter int unsigned MIN_INTERVALO   = 1,
    parameter logic [7:0]  SEMILLA         = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic senal_limpia,
    output logic senal_rebote,
    output logic ocupado
);

    localparam int unsigned CntW       = ANCHO_INTERVALO + 1;
    localparam int unsigned NumToggles = 2 * N_REBOTES + 1;
    localparam int unsigned TogW       = $clog2(NumToggles + 1);

    localparam logic [CntW-1:0] MinCnt       = CntW'(MIN_INTERVALO);
    localparam logic [CntW-1:0] Guarda       = CntW'(2 ** ANCHO_INTERVALO);
    localparam logic [TogW-1:0] UltimoToggle = TogW'(NumToggles - 1);

    estado_t              estado_q, estado_d;
    logic                 sync_q;
    logic                 estable_q, estable_d;
    logic                 objetivo_q, objetivo_d;
    logic                 rebote_q, rebote_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [TogW-1:0]      tog_q, tog_d;
    logic [LfsrAncho-1:0] lfsr;
    logic [CntW-1:0]      intervalo;
    logic                 unused_lfsr;

    lfsr_rebotes #(
        .SEMILLA (SEMILLA)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .valor (lfsr)
    );

    // Only the low ANCHO_INTERVALO bits feed the interval
    assign unused_lfsr = ^lfsr;
    assign intervalo   = MinCnt + CntW'(lfsr[ANCHO_INTERVALO-1:0]);

    always_comb begin
        estado_d   = estado_q;
        estable_d  = estable_q;
        objetivo_d = objetivo_q;
        rebote_d   = rebote_q;
        cnt_d      = cnt_q;
        tog_d      = tog_q;
        ocupado    = 1'b0;
        case (estado_q)
            StReposo: begin
                if (sync_q != estable_q) begin
                    objetivo_d = sync_q;
                    tog_d      = '0;
                    cnt_d      = intervalo;
                    estado_d   = StRebote;
                end
            end
            StRebote: begin
                ocupado = 1'b1;
                if (cnt_q == CntW'(1)) begin
                    rebote_d = ~rebote_q;
                    tog_d    = tog_q + TogW'(1);
                    if (tog_q == UltimoToggle) begin
                        cnt_d    = Guarda;
                        estado_d = StEspera;
                    end else begin
                        cnt_d = intervalo;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StEspera: begin
                ocupado = 1'b1;
                if (cnt_q == CntW'(1)) begin
                    estable_d = objetivo_q;
                    cnt_d     = '0;
                    estado_d  = StReposo;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                estado_d = StReposo;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= StReposo;
            sync_q     <= 1'b0;
            estable_q  <= 1'b0;
            objetivo_q <= 1'b0;
            rebote_q   <= 1'b0;
            cnt_q      <= '0;
            tog_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            sync_q     <= senal_limpia;
            estable_q  <= estable_d;
            objetivo_q <= objetivo_d;
            rebote_q   <= rebote_d;
            cnt_q      <= cnt_d;
            tog_q      <= tog_d;
        end
    end

    assign senal_rebote = rebote_q;

endmodule

// File: tb/tb_generador_rebotes.sv
// Directed bench for generador_rebotes: toggle timestamps against an LFSR reference model.
module tb_generador_rebotes;

    logic clk = 1'b0;
    logic rst_n;
    logic limpia_a, rebote_a, ocupado_a;
    logic limpia_b, rebote_b, ocupado_b;
    logic limpia_c, rebote_c, ocupado_c;

    always #5 clk = ~clk;

    generador_rebotes u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .senal_limpia (limpia_a),
        .senal_rebote (rebote_a),
        .ocupado      (ocupado_a)
    );

    generador_rebotes #(
        .N_REBOTES     (0),
        .MIN_INTERVALO (3)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .senal_limpia (limpia_b),
        .senal_rebote (rebote_b),
        .ocupado      (ocupado_b)
    );

    generador_rebotes #(
        .ANCHO_INTERVALO (2),
        .MIN_INTERVALO   (1)
    ) u_dut_c (
        .clk          (clk),
        .rst_n        (rst_n),
        .senal_limpia (limpia_c),
        .senal_rebote (rebote_c),
        .ocupado      (ocupado_c)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ciclo;
    int unsigned tq_a[$], tq_b[$], tq_c[$];
    int unsigned exp_t[$], obs_t[$], run1[$];
    int unsigned exp_fin;
    int unsigned deb_trans;
    logic        prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0, deb_prev = 1'b0;
    logic        deb_q;
    int unsigned deb_cnt;

    // Edge index since reset release: at the negedge after edge n, ciclo == n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ciclo <= 0;
        else        ciclo <= ciclo + 1;
    end

    // Reference debouncer: output follows input after 5 consecutive differing samples
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= 1'b0;
            deb_cnt <= 0;
        end else if (rebote_c == deb_q) begin
            deb_cnt <= 0;
        end else if (deb_cnt == 4) begin
            deb_q   <= rebote_c;
            deb_cnt <= 0;
        end else begin
            deb_cnt <= deb_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rebote_a != prev_a) tq_a.push_back(ciclo);
            if (rebote_b != prev_b) tq_b.push_back(ciclo);
            if (rebote_c != prev_c) tq_c.push_back(ciclo);
            if (deb_q != deb_prev)  deb_trans++;
        end
        prev_a   = rebote_a;
        prev_b   = rebote_b;
        prev_c   = rebote_c;
        deb_prev = deb_q;
    end

    task automatic verificar(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // LFSR value after n edges: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
    function automatic logic [7:0] lfsr_at(input int unsigned n);
        logic [7:0] x = 8'hA5;
        for (int i = 0; i < int'(n); i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        return x;
    endfunction

    // Appends the toggle edges of a burst whose senal_sync changes at edge k
    task automatic modelo(input int unsigned k, input int unsigned n, input int unsigned minv,
                          input int unsigned a);
        int unsigned e = k + 1;
        for (int i = 0; i < int'(n); i++) begin
            e = e + minv + (int'(lfsr_at(e - 1)) & ((1 << a) - 1));
            exp_t.push_back(e);
        end
        exp_fin = e + (1 << a);
    endtask

    task automatic comparar_rafaga(input string tag);
        verificar({tag, "_n_toggles"}, obs_t.size(), exp_t.size());
        for (int i = 0; i < exp_t.size(); i++) begin
            verificar($sformatf("%s_t%0d", tag, i), (i < obs_t.size()) ? obs_t[i] : 0, exp_t[i]);
        end
    endtask

    function automatic logic ocup(input int sel);
        case (sel)
            0:       return ocupado_a;
            1:       return ocupado_b;
            default: return ocupado_c;
        endcase
    endfunction

    task automatic esperar_libre(input int sel, input string tag);
        int unsigned n = 0;
        @(negedge clk);
        while (ocup(sel) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        verificar({tag, "_libre"}, ocup(sel), 0);
    endtask

    task automatic pulso_reset(input int unsigned ciclos);
        rst_n = 1'b0;
        repeat (ciclos) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned k, d, fuera, ant, n;
        rst_n    = 1'b0;
        limpia_a = 1'b0;
        limpia_b = 1'b0;
        limpia_c = 1'b0;
        repeat (3) @(negedge clk);
        verificar("reset_rebote", rebote_a, 0);
        verificar("reset_ocupado", ocupado_a, 0);

        // Idle after release: no activity at all
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        verificar("reposo_rebote", rebote_a, 0);
        verificar("reposo_ocupado", ocupado_a, 0);
        verificar("reposo_toggles", tq_a.size() + tq_b.size() + tq_c.size(), 0);

        // Default burst 0 -> 1
        tq_a.delete();
        exp_t.delete();
        k = ciclo + 1;
        modelo(k, 7, 1, 4);
        limpia_a = 1'b1;
        @(negedge clk);
        verificar("a_sync_ocupado", ocupado_a, 0);
        @(negedge clk);
        verificar("a_ocupado_sube", ocupado_a, 1);
        esperar_libre(0, "a");
        verificar("a_fin_guarda", ciclo, exp_fin);
        obs_t = tq_a;
        comparar_rafaga("a");
        verificar("a_nivel_final", rebote_a, 1);
        fuera = 0;
        ant = k + 1;
        foreach (tq_a[i]) begin
            d = tq_a[i] - ant;
            if (d < 1 || d > 16) fuera++;
            ant = tq_a[i];
        end
        verificar("a_gaps_rango", fuera, 0);

        // Clean single transition, N_REBOTES=0, MIN_INTERVALO=3
        tq_b.delete();
        exp_t.delete();
        k = ciclo + 1;
        modelo(k, 1, 3, 4);
        limpia_b = 1'b1;
        repeat (2) @(negedge clk);
        verificar("b_ocupado_sube", ocupado_b, 1);
        esperar_libre(1, "b");
        verificar("b_fin_guarda", ciclo, exp_fin);
        obs_t = tq_b;
        comparar_rafaga("b");
        d = (tq_b.size() > 0) ? tq_b[0] - (k + 1) : 0;
        verificar("b_gap_rango", (d >= 3 && d <= 18) ? 1 : 0, 1);
        verificar("b_nivel_final", rebote_b, 1);

        // Mid-burst reversal: first burst completes at 1, second settles at 0
        limpia_a = 1'b0;
        pulso_reset(2);
        repeat (5) @(negedge clk);
        tq_a.delete();
        exp_t.delete();
        k = ciclo + 1;
        modelo(k, 7, 1, 4);
        limpia_a = 1'b1;
        repeat (5) @(negedge clk);
        limpia_a = 1'b0;
        esperar_libre(0, "rev1");
        verificar("rev1_fin_guarda", ciclo, exp_fin);
        verificar("rev1_nivel", rebote_a, 1);
        modelo(exp_fin, 7, 1, 4);
        @(negedge clk);
        verificar("rev2_ocupado_sube", ocupado_a, 1);
        esperar_libre(0, "rev2");
        verificar("rev2_fin_guarda", ciclo, exp_fin);
        obs_t = tq_a;
        comparar_rafaga("rev");
        verificar("rev2_nivel", rebote_a, 0);

        // Reset mid-burst: repeated stimulus reproduces the same timestamps
        pulso_reset(2);
        tq_a.delete();
        repeat (9) @(negedge clk);
        limpia_a = 1'b1;
        repeat (2) @(negedge clk);
        esperar_libre(0, "run1");
        run1 = tq_a;
        limpia_a = 1'b0;
        pulso_reset(2);
        repeat (9) @(negedge clk);
        limpia_a = 1'b1;
        n = 0;
        while (tq_a.size() < run1.size() + 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        verificar("run2_mitad", (tq_a.size() >= run1.size() + 3) ? 1 : 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        verificar("rst_medio_rebote", rebote_a, 0);
        verificar("rst_medio_ocupado", ocupado_a, 0);
        limpia_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tq_a.delete();
        repeat (9) @(negedge clk);
        limpia_a = 1'b1;
        repeat (2) @(negedge clk);
        esperar_libre(0, "run2");
        obs_t = tq_a;
        exp_t = run1;
        comparar_rafaga("repro");

        // A=2 bursts seen through a 5-cycle debouncer: one transition per change
        deb_trans = 0;
        tq_c.delete();
        limpia_c = 1'b1;
        repeat (2) @(negedge clk);
        esperar_libre(2, "c_sube");
        repeat (8) @(negedge clk);
        verificar("c_sube_toggles", tq_c.size(), 7);
        verificar("deb_sube_nivel", deb_q, 1);
        verificar("deb_sube_trans", deb_trans, 1);
        limpia_c = 1'b0;
        repeat (2) @(negedge clk);
        esperar_libre(2, "c_baja");
        repeat (8) @(negedge clk);
        verificar("c_baja_toggles", tq_c.size(), 14);
        verificar("deb_baja_nivel", deb_q, 0);
        verificar("deb_baja_trans", deb_trans, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
